counter_cmp: RTL and testbench

Compare/interrupt unit downstream of the free-running 32-bit system counter. Takes the counter's live value on `count_i`, compares it against a programmable compare register and raises a level interrupt when the count reaches it. Supports one-shot and periodic (auto-reload) modes. Sits on the same device bus as the counter and uses the same one-cycle request/response slave protocol.

---
 rtl/counter_cmp.sv | 152 +++++++++++++++
 tb/tb_counter_cmp.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmp.sv
// counter_cmp: compare/interrupt unit for the free-running system counter.
// One-shot or periodic compare with a level irq and a one-cycle slave bus.
module counter_cmp #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter logic [31:0] CmpBase      = 32'h40010
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               count_i,
  input  logic                      cmp_req_i,
  input  logic [AddressWidth-1:0]   cmp_addr_i,
  input  logic                      cmp_we_i,
  input  logic [DataWidth/8-1:0]    cmp_be_i,
  input  logic [DataWidth-1:0]      cmp_wdata_i,
  output logic                      cmp_rvalid_o,
  output logic [DataWidth-1:0]      cmp_rdata_o,
  output logic                      cmp_err_o,
  output logic                      irq_o
);

  if (DataWidth != 32) begin : g_width_check
    $error("counter_cmp: DataWidth must be 32");
  end

  logic                    en_q, periodic_q, ie_q;
  logic [31:0]             cmp_q, period_q;
  logic                    pending_q, overrun_q;

  logic                    en_d, periodic_d, ie_d;
  logic [31:0]             cmp_d, period_d;
  logic                    pending_d, overrun_d;

  logic [AddressWidth-1:0] off;
  logic                    legal;
  logic [1:0]              sel;
  logic                    wr;
  logic [31:0]             diff;
  logic                    reach;
  logic                    reload;
  logic [31:0]             rd_val;

  assign off    = cmp_addr_i - AddressWidth'(CmpBase);
  assign legal  = (off < AddressWidth'(16)) &&
                  (cmp_addr_i[1:0] == 2'b00);
  assign sel    = off[3:2];
  assign wr     = cmp_req_i & cmp_we_i & legal;

  // Wrap-aware reach: the mod-2^32 difference is non-negative.
  assign diff   = count_i - cmp_q;
  assign reach  = en_q & ~diff[31];
  assign reload = periodic_q & (period_q != 32'd0);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    merge = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // Next register state: reach effects first, bus bytes override.
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    cmp_d      = cmp_q;
    period_d   = period_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    if (reach) begin
      if (reload) cmp_d = cmp_q + period_q;
      else        en_d  = 1'b0;
    end
    if (wr) begin
      unique case (sel)
        2'd0: begin
          if (cmp_be_i[0]) begin
            en_d       = cmp_wdata_i[0];
            periodic_d = cmp_wdata_i[1];
            ie_d       = cmp_wdata_i[2];
          end
        end
        2'd1: cmp_d    = merge(cmp_d, cmp_wdata_i, cmp_be_i);
        2'd2: period_d = merge(period_q, cmp_wdata_i, cmp_be_i);
        default: begin
          if (cmp_be_i[0]) begin
            pending_d = pending_q & ~cmp_wdata_i[0];
            overrun_d = overrun_q & ~cmp_wdata_i[1];
          end
        end
      endcase
    end
    if (reach) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
  end

  // Register file update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      cmp_q      <= '0;
      period_q   <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  // Read mux over the pre-update register values.
  always_comb begin
    rd_val = '0;
    unique case (sel)
      2'd0:    rd_val = {29'd0, ie_q, periodic_q, en_q};
      2'd1:    rd_val = cmp_q;
      2'd2:    rd_val = period_q;
      default: rd_val = {30'd0, overrun_q, pending_q};
    endcase
  end

  // One-cycle bus response; rdata holds between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_rvalid_o <= 1'b0;
      cmp_rdata_o  <= '0;
      cmp_err_o    <= 1'b0;
    end else begin
      cmp_rvalid_o <= cmp_req_i;
      if (cmp_req_i) begin
        cmp_err_o   <= ~legal;
        cmp_rdata_o <= (legal & ~cmp_we_i) ? rd_val : '0;
      end
    end
  end

  assign irq_o = pending_q & ie_q;

endmodule

// File: tb/tb_counter_cmp.sv
// tb_counter_cmp: directed scenarios plus random traffic for counter_cmp.
// A behavioural register model is checked against the DUT every cycle.
module tb_counter_cmp;
  localparam logic [31:0] BASE = 32'h40010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt = '0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        irq;

  int checks = 0;
  int failures = 0;
  bit ramp = 0;

  counter_cmp #(
    .DataWidth(32), .AddressWidth(32), .CmpBase(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .count_i(cnt),
    .cmp_req_i(req), .cmp_addr_i(addr), .cmp_we_i(we),
    .cmp_be_i(be), .cmp_wdata_i(wdata),
    .cmp_rvalid_o(rvalid), .cmp_rdata_o(rdata),
    .cmp_err_o(err), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_en = 0, m_per = 0, m_ie = 0;
  bit          m_pend = 0, m_ovr = 0;
  logic [31:0] m_cmp = '0, m_period = '0;
  bit          m_rvalid = 0, m_err = 0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] bytes_in(
    input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic [31:0] off, rv, n_cmp;
    bit legal, hit, was_pend, n_en;
    int reg_idx;
    off = addr - BASE;
    legal = (off < 16) && (addr % 4 == 0);
    reg_idx = int'(off) / 4;
    rv = 0;
    if (legal) begin
      if (reg_idx == 0) rv = m_en + 2 * m_per + 4 * m_ie;
      if (reg_idx == 1) rv = m_cmp;
      if (reg_idx == 2) rv = m_period;
      if (reg_idx == 3) rv = m_pend + 2 * m_ovr;
    end
    m_rvalid = req;
    if (req) begin
      m_err = !legal;
      m_rdata = (legal && !we) ? rv : 32'd0;
    end
    hit = m_en && (int'(cnt - m_cmp) >= 0);
    was_pend = m_pend;
    n_cmp = m_cmp;
    n_en = m_en;
    if (hit) begin
      if (m_per && m_period != 0) n_cmp = m_cmp + m_period;
      else n_en = 0;
    end
    if (req && we && legal) begin
      if (reg_idx == 0 && be[0]) begin
        n_en = wdata[0]; m_per = wdata[1]; m_ie = wdata[2];
      end
      if (reg_idx == 1) n_cmp = bytes_in(n_cmp, wdata, be);
      if (reg_idx == 2) m_period = bytes_in(m_period, wdata, be);
      if (reg_idx == 3 && be[0]) begin
        if (wdata[0]) m_pend = 0;
        if (wdata[1]) m_ovr = 0;
      end
    end
    if (hit) begin
      m_pend = 1;
      if (was_pend) m_ovr = 1;
    end
    m_cmp = n_cmp;
    m_en = n_en;
  endtask

  // Model advances on the same edge the DUT samples.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
      m_cmp = 0; m_period = 0;
      m_rvalid = 0; m_err = 0; m_rdata = 0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("cyc_rdata", rdata, m_rdata);
      if (m_rvalid) chk("cyc_err", 32'(err), 32'(m_err));
      chk("cyc_irq", 32'(irq), 32'(m_pend && m_ie));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (ramp) cnt = cnt + 1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d,
                    input logic [3:0] m);
    req = 1; we = 1; addr = BASE + off; wdata = d; be = m;
    tick();
    req = 0; we = 0; be = 4'hF;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d,
                    output logic e, output logic v);
    req = 1; we = 0; addr = BASE + off;
    tick();
    d = rdata; e = err; v = rvalid;
    req = 0;
  endtask

  task automatic wait_fire(input string name, input logic [31:0] exp);
    logic [31:0] prev;
    bit found;
    found = 0;
    prev = 32'hDEAD_BEEF;
    for (int i = 0; i < 60 && !found; i++) begin
      prev = cnt;
      tick();
      if (irq) found = 1;
    end
    chk(name, found ? prev : 32'hDEAD_BEEF, exp);
  endtask

  logic [31:0] d;
  logic        e, v;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;
    tick();
    rd(32'h0, d, e, v); chk("rst_ctrl", d, 0);
    rd(32'h4, d, e, v); chk("rst_cmp", d, 0);

    // one-shot
    cnt = 90;
    wr(32'h4, 100, 4'hF);
    wr(32'h0, 5, 4'hF);
    ramp = 1;
    wait_fire("oneshot_fire_at", 100);
    ramp = 0;
    rd(32'h0, d, e, v); chk("oneshot_en_cleared", d, 4);
    rd(32'hC, d, e, v); chk("oneshot_status", d, 1);
    wr(32'hC, 1, 4'h1);
    chk("oneshot_irq_cleared", 32'(irq), 0);

    // periodic
    wr(32'hC, 3, 4'h1);
    cnt = 40;
    wr(32'h4, 50, 4'hF);
    wr(32'h8, 20, 4'hF);
    wr(32'h0, 7, 4'hF);
    ramp = 1;
    wait_fire("periodic_first_at", 50);
    while (cnt < 95) tick();
    ramp = 0;
    rd(32'h4, d, e, v); chk("periodic_cmp", d, 110);
    rd(32'hC, d, e, v); chk("periodic_overrun", d, 3);
    wr(32'h0, 0, 4'hF);
    wr(32'hC, 3, 4'h1);

    // wrap-around
    cnt = 32'hFFFF_FFF0;
    wr(32'h4, 5, 4'hF);
    wr(32'h0, 5, 4'hF);
    ramp = 1;
    wait_fire("wrap_fire_at", 5);
    ramp = 0;
    wr(32'hC, 3, 4'h1);
    cnt = 32'h10;
    wr(32'h4, 32'hFFFF_FFF0, 4'hF);
    wr(32'h0, 5, 4'hF);
    tick();
    chk("wrap_immediate_irq", 32'(irq), 1);
    wr(32'hC, 3, 4'h1);

    // bus errors
    rd(32'h10, d, e, v);
    chk("err_rd_rvalid", 32'(v), 1);
    chk("err_rd_err", 32'(e), 1);
    chk("err_rd_rdata", d, 0);
    wr(32'h2, 7, 4'hF);
    chk("err_wr_err", 32'(err), 1);
    rd(32'h0, d, e, v); chk("err_wr_ctrl_kept", d, 4);

    // back-to-back reads
    req = 1; we = 0; addr = BASE;
    tick();
    chk("b2b_v0", 32'(rvalid), 1); chk("b2b_d0", rdata, 4);
    addr = BASE + 4;
    tick();
    chk("b2b_v1", 32'(rvalid), 1); chk("b2b_d1", rdata, 32'hFFFF_FFF0);
    addr = BASE + 8;
    tick();
    chk("b2b_v2", 32'(rvalid), 1); chk("b2b_d2", rdata, 20);
    req = 0;

    // W1C collides with reach while already pending
    cnt = 210;
    wr(32'h4, 210, 4'hF);
    wr(32'h0, 5, 4'hF);
    tick();
    wr(32'h4, 220, 4'hF);
    wr(32'h0, 5, 4'hF);
    cnt = 220;
    wr(32'hC, 1, 4'h1);
    rd(32'hC, d, e, v); chk("w1c_collide_status", d, 3);
    chk("w1c_collide_irq", 32'(irq), 1);
    wr(32'hC, 3, 4'h1);

    // CMP write collides with periodic reload
    cnt = 300;
    wr(32'h4, 310, 4'hF);
    wr(32'h8, 20, 4'hF);
    wr(32'h0, 7, 4'hF);
    cnt = 310;
    wr(32'h4, 500, 4'hF);
    rd(32'h4, d, e, v); chk("cmp_collide_cmp", d, 500);
    rd(32'h0, d, e, v); chk("cmp_collide_ctrl", d, 7);
    wr(32'h0, 0, 4'hF);
    wr(32'hC, 3, 4'h1);

    // byte enables
    wr(32'h4, 0, 4'hF);
    wr(32'h4, 32'hFFFF_FFFF, 4'h1);
    rd(32'h4, d, e, v); chk("be_cmp", d, 32'h0000_00FF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      logic [31:0] o;
      cnt = cnt + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 9);
        if (k <= 6) o = 32'(k % 4) * 4;
        else if (k == 7) o = 2;
        else if (k == 8) o = 32'h10;
        else o = 32'hFFFF_FFFC;
        req = 1;
        we = $urandom_range(0, 2) != 0;
        addr = BASE + o;
        be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        wdata = (o == 4) ? cnt + $urandom_range(0, 40)
                         : 32'($urandom_range(0, 31));
      end else begin
        req = 0;
      end
      tick();
    end
    req = 0; we = 0; be = 4'hF;

    // reset while irq high and a read in flight
    wr(32'h0, 0, 4'hF);
    wr(32'hC, 3, 4'h1);
    cnt = 1000;
    wr(32'h4, 5, 4'hF);
    wr(32'h0, 5, 4'hF);
    tick();
    chk("mid_irq_before", 32'(irq), 1);
    req = 1; we = 0; addr = BASE;
    @(posedge clk);
    #1;
    rst = 1;
    req = 0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("mid_no_rvalid", 32'(rvalid), 0);
    rd(32'h0, d, e, v); chk("mid_ctrl", d, 0);
    rd(32'h4, d, e, v); chk("mid_cmp", d, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
